// File: rtl/pipe_reg_pkg.sv
// ============================================================================
// Module   : pipe_reg_pkg
// Purpose  : State encoding and occupancy width shared by the pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_reg_pkg;

   localparam int OCC_W = 2;

   // Encoding doubles as the occupancy count, so occupancy is the state flop itself.
   localparam logic [OCC_W-1:0] ST_EMPTY = 2'd0;
   localparam logic [OCC_W-1:0] ST_FULL  = 2'd1;
   localparam logic [OCC_W-1:0] ST_SKID  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pipe_reg_skid_dffe_bank.sv
// ============================================================================
// Module   : dffe_bank
// Purpose  : WIDTH-bit load-enabled register with synchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffe_bank
   import pipe_reg_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clock,
   input  logic             i_clrN,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clock) begin
      if (!i_clrN) begin
         r_q <= RESET_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pipe_reg_skid.sv
// ============================================================================
// Module   : pipe_reg_skid
// Purpose  : Valid/ready pipeline register with optional 1-entry skid buffer and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_skid
   import pipe_reg_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SKID_EN   = 1'b1
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);

   logic [OCC_W-1:0] r_state;
   logic [OCC_W-1:0] w_nextState;
   logic             w_mainLoad;
   logic             w_skidLoad;
   logic             w_outValid;
   logic             w_inReady;
   logic [WIDTH-1:0] w_skidQ;
   logic [WIDTH-1:0] w_mainD;
   logic [WIDTH-1:0] w_mainQ;

   assign w_outValid = (r_state != ST_EMPTY);

   always_ff @(posedge clock) begin
      if (!clr_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_mainLoad  = 1'b0;
      w_skidLoad  = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (in_valid) begin
               w_mainLoad  = 1'b1;
               w_nextState = ST_FULL;
            end
         end
         ST_FULL: begin
            if (in_valid && out_ready) begin
               w_mainLoad = 1'b1;
            end else if (in_valid && SKID_EN) begin
               w_skidLoad  = 1'b1;
               w_nextState = ST_SKID;
            end else if (!in_valid && out_ready) begin
               w_nextState = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (out_ready) begin
               w_mainLoad  = 1'b1;
               w_nextState = ST_FULL;
            end
         end
         default: w_nextState = ST_EMPTY;
      endcase
      // Flush squashes the in-side transfer but leaves the data flops untouched.
      if (flush) begin
         w_nextState = ST_EMPTY;
         w_mainLoad  = 1'b0;
         w_skidLoad  = 1'b0;
      end
   end

   assign w_mainD = (r_state == ST_SKID) ? w_skidQ : in_data;

   dffe_bank #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .i_clock (clock),
      .i_clrN  (clr_n),
      .i_en    (w_mainLoad),
      .i_d     (w_mainD),
      .o_q     (w_mainQ)
   );

   generate
      if (SKID_EN) begin : g_skid
         dffe_bank #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_skid (
            .i_clock (clock),
            .i_clrN  (clr_n),
            .i_en    (w_skidLoad),
            .i_d     (in_data),
            .o_q     (w_skidQ)
         );
         // Registered ready: depends only on state, cutting the out_ready path.
         assign w_inReady = clr_n & (r_state != ST_SKID);
      end else begin : g_noSkid
         assign w_skidQ   = RESET_VAL;
         assign w_inReady = clr_n & (~w_outValid | out_ready);
      end
   endgenerate

   assign in_ready  = w_inReady;
   assign out_valid = w_outValid;
   assign out_data  = w_mainQ;
   assign occupancy = r_state;

endmodule

`default_nettype wire
